pcs_tx_symbol_scheduler: RTL and testbench
==========================================

Name: pcs_tx_symbol_scheduler

Overview:
- Sequences the 8b/10b encoder in the TX PCS.
- Multiplexes the MAC-side symbol stream with periodic SKP ordered sets (COM + SKP_LEN×SKP), presenting one symbol per Bit_Rate_10 cycle to the external combinational encoder core.
- Selects the encoder's RD- or RD+ codeword and tracks true running disparity from the popcount of the selected code, rather than blind toggling.
- Sits between the PIPE TX interface and the serializer.

Parameters:
- SKP_INTERVAL, 1180, DATA-state symbols between SKP ordered sets (≥2).
- SKP_LEN, 3, SKP symbols following each COM (1..7).
- IDLE_SYM, 8'h00, data byte sent when no valid input (K=0).

Ports:
- Bit_Rate_10  in   1   symbol clock, rising edge.
- Rst          in   1   asynchronous, active-high reset.
- enable       in   1   block enable; low forces IDLE.
- TXData       in   8   input symbol byte.
- TXDataK      in   1   input symbol is K-code.
- TXValid      in   1   input symbol valid.
- TXReady      out  1   input accepted when TXValid && TXReady.
- enc_data     out  8   registered symbol to encoder core.
- enc_k        out  1   registered K flag to encoder core.
- data_neg     in   10  encoder codeword for RD-.
- data_pos     in   10  encoder codeword for RD+.
- Data_10      out  10  registered selected codeword to serializer.
- rd_state     out  1   current running disparity (0 = RD-, 1 = RD+).
- code_err     out  1   one-cycle pulse: selected code popcount not in {4,5,6}.
- skp_active   out  1   high while enc_data carries a SKP ordered set.

Behaviour:
- Reset (Rst=1, async): state IDLE, cnt=0, skp_idx=0, rd_state=0, enc_data=IDLE_SYM, enc_k=0, Data_10=0, code_err=0, skp_active=0. TXReady=0.
- States and transitions:
  - IDLE: next DATA if enable=1.
  - DATA: cnt==SKP_INTERVAL-1 → SKP_COM.
  - SKP_COM: → SKP_SKP with skp_idx=0.
  - SKP_SKP: skp_idx==SKP_LEN-1 → DATA with cnt=0.
  - enable=0 in any state → IDLE next cycle, cnt and skp_idx cleared. A SKP set in progress is abandoned.
- TXReady is combinational: high only when state==DATA and enable=1. This includes the cnt==SKP_INTERVAL-1 cycle, so that symbol is still accepted.
- DATA cycle output: if the input is accepted, enc_data/enc_k take TXData/TXDataK on the next edge; otherwise IDLE_SYM with K=0. cnt increments every DATA cycle regardless of TXValid.
- SKP_COM drives 8'hBC/K=1 (K28.5). SKP_SKP drives 8'h1C/K=1 (K28.0). skp_active is registered alongside enc_data.
- IDLE: enc_data=IDLE_SYM, K=0, Data_10 and rd_state hold, no RD update.
- Selection stage (registered, same edge):
  - Data_10 ← rd_state ? data_pos : data_neg.
  - Let ones = popcount(selected). ones≥6 → rd_state←1; ones≤4 → rd_state←0; ones==5 → hold.
  - ones∉{4,5,6} → code_err=1 for one cycle and rd_state holds.
- Latency: accepted symbol appears on enc_data 1 cycle later and on Data_10 2 cycles later.
- enable low → high: rd_state is preserved, not reset. Disparity continuity across enable is required.
- Reset mid-SKP: immediate return to reset values; no partial-set completion.

Decomposition:
- Shared package pcs_pkg holds:
  - K28_5 = 8'hBC and K28_0 = 8'h1C.
  - RD_NEG/RD_POS encodings.
  - The scheduler state enum (IDLE, DATA, SKP_COM, SKP_SKP).
- Sub-module pcs_rd_tracker: popcount, codeword select, rd_state register, code_err. Ports: Bit_Rate_10, Rst, en, data_neg, data_pos, Data_10, rd_state, code_err.

Test Plan:
- Reset then enable=1 with SKP_INTERVAL=4, TXValid=1 continuous → TXReady high for 4 cycles, then low for 1+3 cycles. enc_data sequence: 4 data bytes, BC, 1C, 1C, 1C, then data resumes. skp_active high for exactly 4 cycles.
- Encoder model returns a 6-ones code for data_neg → Data_10=data_neg, rd_state 0→1. Next symbol's Data_10 equals data_pos. A 5-ones code leaves rd_state unchanged.
- TXValid=0 for 3 DATA cycles → enc_data=8'h00, K=0 for 3 cycles. cnt still advances, so SKP arrives on schedule.
- data_neg=10'h3FF (10 ones) → code_err pulses 1 cycle, rd_state unchanged, Data_10=10'h3FF.
- enable dropped during 2nd SKP symbol → IDLE next cycle, TXReady=0, rd_state retained. Re-enable gives a fresh SKP_INTERVAL count.
- Rst asserted mid-DATA between clock edges → all outputs go to reset values immediately, without waiting for a Bit_Rate_10 edge.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared definitions for the TX PCS symbol scheduler and its disparity tracker.
package pcs_pkg;

  // Control symbols used to build SKP ordered sets
  localparam logic [7:0] K28_5 = 8'hBC;  // COM
  localparam logic [7:0] K28_0 = 8'h1C;  // SKP

  // Running disparity encodings
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StSkpCom,
    StSkpSkp
  } sched_state_e;

  // Number of ones in a 10-bit codeword
  function automatic logic [3:0] popcount10(input logic [9:0] code);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, code[i]};
    end
    return ones;
  endfunction

endpackage

// File: rtl/pcs_rd_tracker.sv
// Codeword selector and running-disparity tracker. Picks the RD-/RD+ codeword from the
// external encoder, registers it, and updates disparity from the selected code's weight.
module pcs_rd_tracker
  import pcs_pkg::*;
(
  input  logic       Bit_Rate_10,
  input  logic       Rst,
  input  logic       en,
  input  logic [9:0] data_neg,
  input  logic [9:0] data_pos,
  output logic [9:0] Data_10,
  output logic       rd_state,
  output logic       code_err
);

  logic [9:0] data_10_q, data_10_d;
  logic       rd_state_q, rd_state_d;
  logic       code_err_q, code_err_d;
  logic [9:0] sel_code;
  logic [3:0] ones;

  // Select codeword for current disparity and compute next disparity / error flag
  always_comb begin
    sel_code   = (rd_state_q == RD_POS) ? data_pos : data_neg;
    ones       = popcount10(sel_code);
    data_10_d  = data_10_q;
    rd_state_d = rd_state_q;
    code_err_d = 1'b0;
    if (en) begin
      data_10_d = sel_code;
      if ((ones < 4'd4) || (ones > 4'd6)) begin
        // Illegal weight: flag it and keep disparity rather than guess
        code_err_d = 1'b1;
      end else if (ones == 4'd6) begin
        rd_state_d = RD_POS;
      end else if (ones == 4'd4) begin
        rd_state_d = RD_NEG;
      end
    end
  end

  // Selection stage registers
  always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
    if (Rst) begin
      data_10_q  <= '0;
      rd_state_q <= RD_NEG;
      code_err_q <= 1'b0;
    end else begin
      data_10_q  <= data_10_d;
      rd_state_q <= rd_state_d;
      code_err_q <= code_err_d;
    end
  end

  assign Data_10  = data_10_q;
  assign rd_state = rd_state_q;
  assign code_err = code_err_q;

endmodule

// File: rtl/pcs_tx_symbol_scheduler.sv
// TX PCS symbol scheduler: interleaves MAC symbols with periodic SKP ordered sets,
// feeds the external 8b/10b encoder core and tracks running disparity of its output.
module pcs_tx_symbol_scheduler
  import pcs_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 3,
  parameter logic [7:0]  IDLE_SYM     = 8'h00
) (
  input  logic       Bit_Rate_10,
  input  logic       Rst,
  input  logic       enable,
  input  logic [7:0] TXData,
  input  logic       TXDataK,
  input  logic       TXValid,
  output logic       TXReady,
  output logic [7:0] enc_data,
  output logic       enc_k,
  input  logic [9:0] data_neg,
  input  logic [9:0] data_pos,
  output logic [9:0] Data_10,
  output logic       rd_state,
  output logic       code_err,
  output logic       skp_active
);

  localparam int unsigned    CntW    = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SKP_INTERVAL - 1);
  localparam logic [2:0]     SkpLast = 3'(SKP_LEN - 1);

  sched_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      skp_idx_q, skp_idx_d;
  logic [7:0]      enc_data_q, enc_data_d;
  logic            enc_k_q, enc_k_d;
  logic            skp_active_q, skp_active_d;
  logic            tx_ready;

  assign tx_ready = (state_q == StData) && enable;

  // Next-state and next-symbol selection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    skp_idx_d    = skp_idx_q;
    enc_data_d   = IDLE_SYM;
    enc_k_d      = 1'b0;
    skp_active_d = 1'b0;
    if (!enable) begin
      // Dropping enable abandons any SKP set in progress
      state_d   = StIdle;
      cnt_d     = '0;
      skp_idx_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StData;
        end
        StData: begin
          if (TXValid && tx_ready) begin
            enc_data_d = TXData;
            enc_k_d    = TXDataK;
          end
          // Interval counts DATA cycles, not accepted symbols
          if (cnt_q == CntLast) begin
            state_d = StSkpCom;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StSkpCom: begin
          enc_data_d   = K28_5;
          enc_k_d      = 1'b1;
          skp_active_d = 1'b1;
          state_d      = StSkpSkp;
          skp_idx_d    = '0;
        end
        StSkpSkp: begin
          enc_data_d   = K28_0;
          enc_k_d      = 1'b1;
          skp_active_d = 1'b1;
          if (skp_idx_q == SkpLast) begin
            state_d   = StData;
            cnt_d     = '0;
            skp_idx_d = '0;
          end else begin
            skp_idx_d = skp_idx_q + 3'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Scheduler state and registered encoder-side outputs
  always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
    if (Rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      skp_idx_q    <= '0;
      enc_data_q   <= IDLE_SYM;
      enc_k_q      <= 1'b0;
      skp_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      skp_idx_q    <= skp_idx_d;
      enc_data_q   <= enc_data_d;
      enc_k_q      <= enc_k_d;
      skp_active_q <= skp_active_d;
    end
  end

  assign TXReady    = tx_ready;
  assign enc_data   = enc_data_q;
  assign enc_k      = enc_k_q;
  assign skp_active = skp_active_q;

  // Disparity only advances while the scheduler is active
  pcs_rd_tracker u_rd_tracker (
    .Bit_Rate_10 (Bit_Rate_10),
    .Rst         (Rst),
    .en          (state_q != StIdle),
    .data_neg    (data_neg),
    .data_pos    (data_pos),
    .Data_10     (Data_10),
    .rd_state    (rd_state),
    .code_err    (code_err)
  );

endmodule

// File: tb/tb_pcs_tx_symbol_scheduler.sv
// Directed bench for pcs_tx_symbol_scheduler with a short SKP interval.
module tb_pcs_tx_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] enc_data;
  logic       enc_k;
  logic [9:0] data_neg;
  logic [9:0] data_pos;
  logic [9:0] data_10;
  logic       rd_state;
  logic       code_err;
  logic       skp_active;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pcs_tx_symbol_scheduler #(
    .SKP_INTERVAL (4),
    .SKP_LEN      (3),
    .IDLE_SYM     (8'h00)
  ) dut (
    .Bit_Rate_10 (clk),
    .Rst         (rst),
    .enable      (enable),
    .TXData      (tx_data),
    .TXDataK     (tx_k),
    .TXValid     (tx_valid),
    .TXReady     (tx_ready),
    .enc_data    (enc_data),
    .enc_k       (enc_k),
    .data_neg    (data_neg),
    .data_pos    (data_pos),
    .Data_10     (data_10),
    .rd_state    (rd_state),
    .code_err    (code_err),
    .skp_active  (skp_active)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       k;
    logic       exp_ready;
    logic [7:0] exp_enc;
    logic       exp_k;
    logic       exp_skp;
    logic [9:0] exp_d10;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic found;

    // valid data k | ready enc k skp | d10
    vecs[0]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000};
    vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'h000};
    vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 10'h155};
    vecs[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 10'h155};
    vecs[4]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 10'h155};
    vecs[5]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0, 10'h155};
    vecs[6]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 10'h155};
    vecs[7]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[8]  = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[9]  = '{1'b1, 8'hFB, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[10] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'hFB, 1'b1, 1'b0, 10'h155};
    vecs[11] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'h155};
    vecs[12] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'h155};
    vecs[13] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h155};
    vecs[14] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1, 10'h155};
    vecs[15] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[16] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[17] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b1, 10'h155};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 10'h155};

    rst      = 1'b1;
    enable   = 1'b0;
    tx_data  = 8'h00;
    tx_k     = 1'b0;
    tx_valid = 1'b0;
    data_neg = 10'h155;  // 5 ones
    data_pos = 10'h155;
    step();
    step();
    rst = 1'b0;

    // Reset values
    check("rst ready", 32'(tx_ready), 32'd0);
    check("rst enc_data", 32'(enc_data), 32'h00);
    check("rst d10", 32'(data_10), 32'h000);
    check("rst rd", 32'(rd_state), 32'd0);
    check("rst skp", 32'(skp_active), 32'd0);

    // Symbol stream with SKP insertion and idle fill
    enable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tx_valid = vecs[i].valid;
      tx_data  = vecs[i].data;
      tx_k     = vecs[i].k;
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(tx_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d enc_data", i), 32'(enc_data), 32'(vecs[i].exp_enc));
      check($sformatf("vec%0d enc_k", i), 32'(enc_k), 32'(vecs[i].exp_k));
      check($sformatf("vec%0d skp", i), 32'(skp_active), 32'(vecs[i].exp_skp));
      check($sformatf("vec%0d d10", i), 32'(data_10), 32'(vecs[i].exp_d10));
      check($sformatf("vec%0d rd", i), 32'(rd_state), 32'd0);
      step();
    end
    tx_valid = 1'b0;

    // Disparity tracking from codeword weight
    data_neg = 10'h0FC;  // 6 ones
    data_pos = 10'h303;  // 4 ones
    step();
    check("rd6 d10", 32'(data_10), 32'h0FC);
    check("rd6 rd", 32'(rd_state), 32'd1);
    check("rd6 err", 32'(code_err), 32'd0);
    step();
    check("rd4 d10", 32'(data_10), 32'h303);
    check("rd4 rd", 32'(rd_state), 32'd0);
    data_neg = 10'h155;
    data_pos = 10'h2AA;  // both 5 ones
    step();
    check("rd5neg d10", 32'(data_10), 32'h155);
    check("rd5neg rd", 32'(rd_state), 32'd0);
    data_neg = 10'h0FC;
    step();
    check("rd6b rd", 32'(rd_state), 32'd1);
    data_neg = 10'h155;
    step();
    check("rd5pos d10", 32'(data_10), 32'h2AA);
    check("rd5pos rd", 32'(rd_state), 32'd1);
    data_pos = 10'h303;
    step();
    check("rd4b rd", 32'(rd_state), 32'd0);

    // Illegal weight: error pulse, disparity held
    data_neg = 10'h3FF;
    data_pos = 10'h000;
    step();
    check("err d10", 32'(data_10), 32'h3FF);
    check("err pulse", 32'(code_err), 32'd1);
    check("err rd", 32'(rd_state), 32'd0);
    data_neg = 10'h155;
    data_pos = 10'h2AA;
    step();
    check("err clear", 32'(code_err), 32'd0);
    check("err after d10", 32'(data_10), 32'h155);

    // Drive RD+ then abandon a SKP set mid-way
    data_neg = 10'h0FC;
    data_pos = 10'h2AA;
    step();
    step();
    check("pre-drop rd", 32'(rd_state), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (tx_ready) found = 1'b1;
      else step();
    end
    check("wait ready high", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (!tx_ready) found = 1'b1;
      else step();
    end
    check("wait com", 32'(found), 32'd1);
    step();
    check("skp0 enc", 32'(enc_data), 32'hBC);
    step();
    check("skp1 enc", 32'(enc_data), 32'h1C);
    enable = 1'b0;
    step();
    check("drop ready", 32'(tx_ready), 32'd0);
    check("drop enc", 32'(enc_data), 32'h00);
    check("drop k", 32'(enc_k), 32'd0);
    check("drop skp", 32'(skp_active), 32'd0);
    check("drop rd", 32'(rd_state), 32'd1);
    check("drop d10", 32'(data_10), 32'h2AA);
    data_neg = 10'h0FF;
    data_pos = 10'h3FF;
    step();
    check("idle d10 hold", 32'(data_10), 32'h2AA);
    check("idle no err", 32'(code_err), 32'd0);
    check("idle rd hold", 32'(rd_state), 32'd1);

    // Re-enable: fresh interval of 4 DATA cycles, disparity kept
    data_neg = 10'h0FC;
    data_pos = 10'h2AA;
    enable   = 1'b1;
    check("reen idle ready", 32'(tx_ready), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_ready) cnt++;
      else if (cnt > 0) break;
    end
    check("reen data cycles", 32'(cnt), 32'd4);
    check("reen rd", 32'(rd_state), 32'd1);

    // Asynchronous reset between edges while in DATA
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (tx_ready) found = 1'b1;
      else step();
    end
    check("wait data", 32'(found), 32'd1);
    step();
    check("pre-rst enc", 32'(enc_data), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    check("arst enc", 32'(enc_data), 32'h00);
    check("arst k", 32'(enc_k), 32'd0);
    check("arst ready", 32'(tx_ready), 32'd0);
    check("arst d10", 32'(data_10), 32'h000);
    check("arst rd", 32'(rd_state), 32'd0);
    check("arst err", 32'(code_err), 32'd0);
    check("arst skp", 32'(skp_active), 32'd0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
